fc_weight_loader: RTL
=====================

Name: fc_weight_loader

Overview:
Write-side front end for the 128-lane FC weight buffer. It accepts a packed weight byte stream through a valid/ready handshake and assembles one full row of LANES weights in a shadow register. It then issues a single broadcast write of that row to all lanes at the same row address. It sits between the DMA/stream source and the buffer's write port, and it yields to the buffer's read path, which owns the shared address mux while reading.

Parameters:
LANES, 128, number of buffer lanes (one 8-bit weight per lane per row)
DEPTH, 84, rows per lane buffer
BEAT_BYTES, 4, weight bytes per input beat; LANES % BEAT_BYTES == 0
PTR_W, 7, row address width; 2^PTR_W >= DEPTH

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start_i  in  1  begin load; sampled only in IDLE
num_rows_i  in  PTR_W  rows to load; captured on start_i
s_valid_i  in  1  input beat valid
s_data_i  in  8*BEAT_BYTES  beat; byte k (bits 8k+7:8k) maps to lane beat_idx*BEAT_BYTES+k
s_ready_o  out  1  loader accepts beat
rd_busy_i  in  1  buffer read active (rden); blocks writes
wren_o  out  1  buffer write enable
wrptr_o  out  PTR_W x LANES  per-lane write row; all lanes carry the same value
weight_o  out  8 x LANES  row data to buffer
busy_o  out  1  not IDLE
done_o  out  1  one-cycle pulse at end of load

Behaviour:
- FSM states: IDLE, FILL, WRITE, DONE. Reset (rst=1 at clk edge) forces:
  - state IDLE; row_cnt=0; beat_cnt=0; shadow register all 0.
  - wren_o=0, s_ready_o=0, busy_o=0, done_o=0, wrptr_o=0, weight_o=0.
- Reset mid-load discards any partial row and issues no further writes. Rows already written stay in the buffer.
- IDLE:
  - On start_i=1, capture rows = min(num_rows_i, DEPTH).
  - rows==0 -> DONE with no writes; otherwise -> FILL with row_cnt=0, beat_cnt=0.
- FILL:
  - s_ready_o=1. A beat is accepted when s_valid_i & s_ready_o; its bytes go into shadow lanes beat_cnt*BEAT_BYTES .. +BEAT_BYTES-1, and beat_cnt increments.
  - The beat with beat_cnt==LANES/BEAT_BYTES-1 is the last beat: beat_cnt wraps to 0 and the state goes to WRITE.
  - No beat accepted -> state unchanged.
- WRITE:
  - s_ready_o=0. wren_o = !rd_busy_i (combinational).
  - wrptr_o[i]=row_cnt for all i. weight_o = shadow (registered; stable through WRITE).
  - When wren_o=1: if row_cnt==rows-1, go to DONE; else row_cnt++ and go to FILL.
  - When rd_busy_i=1: hold in WRITE with wren_o=0 and the outputs stable, indefinitely.
- DONE: done_o=1 for exactly one cycle, then IDLE.
- Latency: with no read stall, the row write occurs in the cycle after the last beat is accepted. Throughput is LANES/BEAT_BYTES+1 cycles per row.
- start_i outside IDLE is ignored. busy_o=1 in FILL, WRITE and DONE.
- wrptr_o and wren_o are 0 in every state other than WRITE.

Optional Feature:
- Macro FC_WLOAD_LAST_EN. When defined:
  - Adds input port s_last_i (1 bit), sampled with each accepted beat.
  - A beat with s_last_i=1 ends the current row: lanes not yet filled are zeroed, and the state goes to WRITE.
  - After that WRITE the state goes to DONE regardless of row_cnt vs rows (early termination).
  - s_last_i on the natural last beat of the final row behaves as normal.
- Without the macro: no s_last_i port; termination depends only on the captured row count.

Test Plan:
- Basic load: num_rows_i=2, 64 beats of incrementing bytes (0x00..) with s_valid_i constant -> wren_o pulses at cycles 33 and 66 after FILL entry. Row 0 has lane0=0x00 and lane127=0x7F; row 1 lane0=0x80; wrptr 0 then 1. done_o pulses once.
- Read interlock: hold rd_busy_i=1 for 10 cycles while in WRITE -> wren_o stays 0, s_ready_o=0, weight_o unchanged. Write occurs the cycle rd_busy_i drops.
- Bounds: num_rows_i=0 -> done_o one cycle later, no wren_o. num_rows_i=100 -> exactly 84 writes with wrptr 0..83.
- Backpressure gaps: s_valid_i toggling every other cycle -> identical row contents as the back-to-back case, with the write delayed accordingly.
- Reset mid-operation: assert rst after 17 beats of row 3 -> next cycle IDLE, all outputs 0. A fresh start with num_rows_i=1 writes row 0 correctly with no leftover data.
- With FC_WLOAD_LAST_EN: s_last_i on beat 5 of row 0 -> lanes 24..127 are 0, one write at wrptr 0, then done_o.

Source files
------------

// File: rtl/fc_weight_loader.sv
// Row assembler for the FC weight buffer: packs byte beats into a shadow row, then broadcasts it to every lane.
// Optional FC_WLOAD_LAST_EN adds s_last_i for early row/load termination with zero fill of the remaining lanes.
module fc_weight_loader #(
    parameter int LANES      = 128,
    parameter int DEPTH      = 84,
    parameter int BEAT_BYTES = 4,
    parameter int PTR_W      = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [PTR_W-1:0]        num_rows_i,
    input  logic                    s_valid_i,
    input  logic [8*BEAT_BYTES-1:0] s_data_i,
`ifdef FC_WLOAD_LAST_EN
    input  logic                    s_last_i,
`endif
    output logic                    s_ready_o,
    input  logic                    rd_busy_i,
    output logic                    wren_o,
    output logic [PTR_W*LANES-1:0]  wrptr_o,
    output logic [8*LANES-1:0]      weight_o,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam int NBEATS = LANES / BEAT_BYTES;
    localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int BW     = 8 * BEAT_BYTES;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]         state;
    logic [PTR_W-1:0]   rows;
    logic [PTR_W-1:0]   row_cnt;
    logic [BEAT_W-1:0]  beat_cnt;
    logic [8*LANES-1:0] shadow;
    logic               last_seen;
    logic               in_last;
    logic               accept;
    logic               row_end;
    logic [PTR_W-1:0]   rows_req;

`ifdef FC_WLOAD_LAST_EN
    assign in_last = s_last_i;
`else
    assign in_last = 1'b0;
`endif

    // Requests beyond the buffer depth are clipped rather than wrapping the row address.
    assign rows_req = (int'(num_rows_i) > DEPTH) ? PTR_W'(DEPTH) : num_rows_i;
    assign accept   = (state == S_FILL) && s_valid_i;
    assign row_end  = (beat_cnt == BEAT_W'(NBEATS - 1)) || in_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            rows      <= '0;
            row_cnt   <= '0;
            beat_cnt  <= '0;
            shadow    <= '0;
            last_seen <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        rows      <= rows_req;
                        row_cnt   <= '0;
                        beat_cnt  <= '0;
                        last_seen <= 1'b0;
                        state     <= (rows_req == '0) ? S_DONE : S_FILL;
                    end
                end
                S_FILL: begin
                    if (accept) begin
                        // A last-flagged beat zeroes every lane slot above it so no stale bytes leak out.
                        for (int b = 0; b < NBEATS; b++) begin
                            if (BEAT_W'(b) == beat_cnt)
                                shadow[b*BW +: BW] <= s_data_i;
                            else if (in_last && (BEAT_W'(b) > beat_cnt))
                                shadow[b*BW +: BW] <= '0;
                        end
                        if (row_end) begin
                            beat_cnt  <= '0;
                            last_seen <= in_last;
                            state     <= S_WRITE;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    if (!rd_busy_i) begin
                        if ((row_cnt == rows - 1'b1) || last_seen) begin
                            state <= S_DONE;
                        end else begin
                            row_cnt <= row_cnt + 1'b1;
                            state   <= S_FILL;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Valid/ready: a beat transfers on any rising edge where s_valid_i and s_ready_o are both high.
    assign s_ready_o = (state == S_FILL);
    assign wren_o    = (state == S_WRITE) && !rd_busy_i;
    assign wrptr_o   = (state == S_WRITE) ? {LANES{row_cnt}} : '0;
    assign weight_o  = shadow;
    assign busy_o    = (state != S_IDLE);
    assign done_o    = (state == S_DONE);

endmodule
